// File: rtl/fft_sched_pkg.sv
// Shared types and defaults for the FFT frame scheduler: FSM states, parameter
// defaults, counter widths and a width helper.
package fft_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  localparam int BEATS_DEF        = 32;
  localparam int MAX_INFLIGHT_DEF = 2;
  localparam int MIN_GAP_DEF      = 0;
  localparam int TIMEOUT_DEF      = 4096;

  localparam int FRAME_CNT_W = 16;
  localparam int INFLIGHT_W  = 2;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_wdog.sv
// Stall watchdog: counts enabled cycles, pulses expire combinationally on the
// TIMEOUT-th consecutive one; restart/clear zero it, and it saturates once expired.
module fft_wdog
  import fft_sched_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic cnt_en,
  input  logic restart,
  input  logic clear,
  output logic expire
);

  localparam int W = cnt_w(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  assign expire = cnt_en && !restart && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear || restart) begin
      cnt <= '0;
    end else if (cnt_en && (cnt != LAST)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// Schedules whole frames from the upstream buffer into the FFT, capping frames in flight.
// rd_en registered off the FSM, fft_din_valid one cycle later; starts hold off while the pipeline is full.
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int BEATS        = BEATS_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int MIN_GAP      = MIN_GAP_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic                   buf_frame_rdy,
  output logic                   rd_en,
  output logic                   fft_din_valid,
  input  logic                   fft_dout_en,
  input  logic                   clr,
  output logic                   busy,
  output logic [INFLIGHT_W-1:0]  inflight,
  output logic [FRAME_CNT_W-1:0] frames_in,
  output logic [FRAME_CNT_W-1:0] frames_out,
  output logic                   frame_done,
  output logic                   err_timeout,
  output logic                   err_spurious
);

  localparam int BW = cnt_w((BEATS > MIN_GAP) ? BEATS : MIN_GAP);
  localparam int OW = cnt_w(BEATS);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);
  localparam logic [OW-1:0] OUT_LAST  = OW'(BEATS - 1);
  localparam logic [INFLIGHT_W-1:0] INFL_MAX = INFLIGHT_W'(MAX_INFLIGHT);

  sched_state_t  state;
  logic [BW-1:0] beat_cnt;
  logic [OW-1:0] out_cnt;
  logic          dout_ok;
  logic          done_now;
  logic          start;
  logic          wd_expire;

  assign dout_ok  = fft_dout_en && (inflight != '0);
  assign done_now = dout_ok && (out_cnt == OUT_LAST);
  // A frame completing this cycle frees its slot for a start in the same cycle.
  assign start    = (state == IDLE) && enable && buf_frame_rdy && !err_timeout &&
                    ((inflight < INFL_MAX) || done_now);
  assign busy     = (state != IDLE) || (inflight != '0);

  // beat_cnt doubles as the GAP cycle counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      beat_cnt <= '0;
      rd_en    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= READ;
            beat_cnt <= '0;
            rd_en    <= 1'b1;
          end
        end
        READ: begin
          if (beat_cnt == BEAT_LAST) begin
            state    <= (MIN_GAP > 0) ? GAP : IDLE;
            beat_cnt <= '0;
            rd_en    <= 1'b0;
          end else begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        GAP: begin
          if (beat_cnt == GAP_LAST) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
          rd_en    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fft_din_valid <= 1'b0;
      frame_done    <= 1'b0;
      out_cnt       <= '0;
      inflight      <= '0;
      frames_in     <= '0;
      frames_out    <= '0;
      err_timeout   <= 1'b0;
      err_spurious  <= 1'b0;
    end else begin
      fft_din_valid <= rd_en;
      frame_done    <= done_now;
      if (dout_ok) begin
        out_cnt <= done_now ? '0 : out_cnt + OW'(1);
      end
      if (start && !done_now) begin
        inflight <= inflight + INFLIGHT_W'(1);
      end else if (done_now && !start) begin
        inflight <= inflight - INFLIGHT_W'(1);
      end
      if (clr) begin
        frames_in    <= '0;
        frames_out   <= '0;
        err_timeout  <= 1'b0;
        err_spurious <= 1'b0;
      end else begin
        if (start)     frames_in  <= frames_in + FRAME_CNT_W'(1);
        if (done_now)  frames_out <= frames_out + FRAME_CNT_W'(1);
        if (wd_expire) err_timeout <= 1'b1;
        if (fft_dout_en && (inflight == '0)) err_spurious <= 1'b1;
      end
    end
  end

  fft_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rstn   (rstn),
    .cnt_en ((inflight != '0) && !fft_dout_en),
    .restart(fft_dout_en || (inflight == '0)),
    .clear  (clr),
    .expire (wd_expire)
  );

endmodule

// File: doc/fft_frame_sched.md
FFT_FRAME_SCHED -- requirements
Module: fft_frame_sched

Interface
REQ-001 Parameter BEATS, default 32, SHALL set the 16-lane beats per 512-point frame, both input and output.
REQ-002 Parameter MAX_INFLIGHT, default 2, SHALL set the maximum number of frames inside the FFT pipeline at once.
REQ-003 Parameter MIN_GAP, default 0, SHALL set the idle cycles forced between consecutive input frames.
REQ-004 Parameter TIMEOUT, default 4096, SHALL set the cycles without dout_en, while frames are in flight, before a stall error.
REQ-005 clk  in  1  clock.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 enable  in  1  allows new frame starts.
REQ-008 buf_frame_rdy  in  1  upstream buffer holds at least one complete frame.
REQ-009 rd_en  out  1  read strobe to the upstream buffer, one beat per cycle.
REQ-010 fft_din_valid  out  1  din_valid for the FFT pipeline.
REQ-011 fft_dout_en  in  1  dout_en from the FFT pipeline.
REQ-012 clr  in  1  synchronous clear of errors and counters.
REQ-013 busy  out  1  state not IDLE, or inflight > 0.
REQ-014 inflight  out  2  frames started but not yet fully output.
REQ-015 frames_in / frames_out  out  16 each  wrapping frame counters.
REQ-016 frame_done  out  1  one-cycle pulse on the last output beat of a frame.
REQ-017 err_timeout / err_spurious  out  1 each  sticky error flags.

Function
REQ-018 FSM states SHALL be IDLE, READ and GAP.
REQ-019 IDLE -> READ SHALL occur when enable && buf_frame_rdy && inflight < MAX_INFLIGHT && !err_timeout.
- On entry: beat_cnt = 0, inflight increments, frames_in increments.
REQ-020 In READ, rd_en SHALL be 1 for exactly BEATS consecutive cycles, with no gaps.
- Transition on beat_cnt == BEATS-1: to GAP if MIN_GAP > 0, else to IDLE.
REQ-021 A frame in READ SHALL always complete; deasserting enable affects only the next start.
REQ-022 GAP SHALL last MIN_GAP cycles with rd_en = 0, then go to IDLE.
REQ-023 IDLE SHALL be able to start a new frame in the cycle after READ ends, giving back-to-back frames with a 1-cycle bubble.
REQ-024 fft_din_valid SHALL equal rd_en delayed by exactly 1 cycle (buffer read latency).
REQ-025 Output tracking: each fft_dout_en cycle increments out_cnt.
- At out_cnt == BEATS-1: pulse frame_done, reset out_cnt to 0, decrement inflight, increment frames_out.
REQ-026 If frame start and frame completion fall in the same cycle, inflight SHALL be unchanged.
REQ-027 fft_dout_en with inflight == 0 SHALL set err_spurious.
- The beat is ignored and no counter changes.
REQ-028 The watchdog SHALL count cycles while inflight > 0 && !fft_dout_en.
- It resets on any fft_dout_en or when inflight == 0.
- Reaching TIMEOUT sets err_timeout, which blocks new starts.
REQ-029 clr SHALL zero the errors, frames_in, frames_out and the watchdog.
- It SHALL NOT affect the FSM, inflight or out_cnt.
- clr in the same cycle as an error event: clr wins.
REQ-030 frames_in and frames_out SHALL wrap modulo 2^16 with no flag.
REQ-031 All outputs SHALL be registered except busy, which may be combinational from registers.

Reset
REQ-032 On rstn low, immediately:
- FSM = IDLE.
- All outputs 0.
- beat_cnt, out_cnt, inflight, watchdog and counters 0.
REQ-033 Reset mid-frame SHALL abandon the frame with no recovery state; the upstream buffer and FFT pipeline are reset by the same rstn.

Structure
REQ-034 Package fft_sched_pkg SHALL hold:
- the state enum;
- the BEATS, MAX_INFLIGHT, MIN_GAP and TIMEOUT defaults;
- the counter width localparams.
REQ-035 The watchdog SHALL be the sub-module fft_wdog (inputs: count enable, restart, clear; output: expire pulse).
- FSM and counters remain in fft_frame_sched.

Verification
REQ-036 Single frame: buf_frame_rdy = 1 for 1 cycle, enable = 1.
- Expect rd_en high for exactly 32 cycles and fft_din_valid the same 32 cycles shifted +1.
- Then feed 32 dout_en: expect frame_done on the 32nd, inflight 1 -> 0, frames_in = frames_out = 1.
REQ-037 Backpressure: buf_frame_rdy held 1 with no dout_en.
- Expect exactly 2 frames started (64 rd_en cycles) and inflight = 2, then no further rd_en.
- After 32 dout_en, a third frame starts.
REQ-038 Simultaneous: final output beat of frame 1 coincides with the start cycle of frame 3.
- Expect inflight stays 2 and frame_done pulses.
REQ-039 Stall: inflight = 1 with no dout_en for 4096 cycles.
- Expect err_timeout set and no new start despite buf_frame_rdy.
- After clr, err_timeout clears and starts resume.
REQ-040 Spurious, then reset: dout_en pulse with inflight = 0 sets err_spurious.
- rstn low mid-READ (beat 10) zeros every output in the same cycle; after release the FSM is IDLE.
REQ-041 MIN_GAP = 3: with buf_frame_rdy held high, consecutive rd_en bursts SHALL be separated by 4 idle cycles (3 GAP cycles plus the IDLE decision cycle).
